// File: rtl/load_data_ctr_if.sv
// Load-path bus between the execute/memory stages and load_data_ctr.
// The master side drives the load request, memory read words and I/O responses.
interface load_data_ctr_if;
   logic [5:0]  opcode;
   logic [31:0] ALUOut;
   logic        stall;
   logic [31:0] dataMemOut;
   logic [31:0] instrMemOut;
   logic [31:0] ISR_MemOut;
   logic [31:0] ioRdData;
   logic        ioRdValid;
   logic        ioRdReq;
   logic [31:0] ioAddr;
   logic [31:0] loadData;
   logic        loadValid;
   logic        loadStall;
   logic        ioTimeout;

   modport master (
      output opcode, ALUOut, stall, dataMemOut, instrMemOut, ISR_MemOut, ioRdData, ioRdValid,
      input  ioRdReq, ioAddr, loadData, loadValid, loadStall, ioTimeout
   );

   modport slave (
      input  opcode, ALUOut, stall, dataMemOut, instrMemOut, ISR_MemOut, ioRdData, ioRdValid,
      output ioRdReq, ioAddr, loadData, loadValid, loadStall, ioTimeout
   );
endinterface

// File: rtl/load_data_ctr.sv
// Memory-stage load path: captures a load, selects data/instr/ISR/I-O word, aligns and extends it.
// Optional I/O abort timer is built only when LOAD_IO_TIMEOUT_EN is defined.
//
// state      | meaning
// IDLE       | no load in flight; capture allowed when stall=0
// RESP       | memory/none-region load result on loadData (loadValid=1)
// IO_WAIT    | I/O request outstanding; pipeline stalled
// IO_DONE    | I/O result (or timeout zero) presented from the hold register
module load_data_ctr #(
   parameter int IO_TIMEOUT = 255
) (
   input logic            clk,
   input logic            rst,
   load_data_ctr_if.slave bus
);
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_IO_WAIT, ST_IO_DONE} state_t;
   typedef enum logic [2:0] {RG_NONE, RG_DATA, RG_INSTR, RG_ISR, RG_IO} region_t;

   if (IO_TIMEOUT < 1) begin : g_bad_timeout
      $error("IO_TIMEOUT must be at least 1");
   end

   state_t      state_q;
   logic        cap_valid_q;
   logic [5:0]  cap_op_q;
   logic [1:0]  cap_off_q;
   region_t     cap_region_q;
   logic [31:0] hold_q;
   logic [31:0] io_addr_q;
   logic        io_req_q;
   logic        load_valid_q;
   logic        load_stall_q;
   logic        resp_live_q;

`ifdef LOAD_IO_TIMEOUT_EN
   localparam int TW = $clog2(IO_TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt_q;
   logic          io_timeout_q;
`endif

   region_t     region_d;
   logic        is_load_d;
   logic        cap_en;
   logic [31:0] mem_word;
   logic [31:0] live_data;
   logic [31:0] load_data;

   function automatic logic [31:0] align_load(input logic [5:0] op, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'b00:   b = w[31:24];
         2'b01:   b = w[23:16];
         2'b10:   b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (op)
         OP_LB:   align_load = {{24{b[7]}}, b};
         OP_LBU:  align_load = {24'h0, b};
         OP_LH:   align_load = {{16{h[15]}}, h};
         OP_LHU:  align_load = {16'h0, h};
         default: align_load = w;
      endcase
   endfunction

   // Region priority: data (0x1/0x3) beats instruction (0x2), then ISR, then I/O.
   always_comb begin
      region_d = RG_NONE;
      if (bus.ALUOut[31:30] == 2'b00 && bus.ALUOut[28])
         region_d = RG_DATA;
      else if (bus.ALUOut[31:30] == 2'b00 && bus.ALUOut[29])
         region_d = RG_INSTR;
      else if (bus.ALUOut[31:28] == 4'b1100)
         region_d = RG_ISR;
      else if (bus.ALUOut[31:28] == 4'b1000)
         region_d = RG_IO;
   end

   assign is_load_d = bus.opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   assign cap_en    = !bus.stall && (state_q == ST_IDLE || state_q == ST_RESP);

   always_comb begin
      mem_word = 32'h0;
      if (cap_valid_q) begin
         case (cap_region_q)
            RG_DATA:  mem_word = bus.dataMemOut;
            RG_INSTR: mem_word = bus.instrMemOut;
            RG_ISR:   mem_word = bus.ISR_MemOut;
            default:  mem_word = 32'h0;
         endcase
      end
   end

   assign live_data = align_load(cap_op_q, cap_off_q, mem_word);

   // First RESP cycle shows the live memory word; a stalled RESP replays the snapshot.
   always_comb begin
      load_data = 32'h0;
      case (state_q)
         ST_RESP:    load_data = resp_live_q ? live_data : hold_q;
         ST_IO_DONE: load_data = hold_q;
         default:    load_data = 32'h0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cap_valid_q  <= 1'b0;
         cap_op_q     <= 6'h0;
         cap_off_q    <= 2'b00;
         cap_region_q <= RG_NONE;
         hold_q       <= 32'h0;
         io_addr_q    <= 32'h0;
         io_req_q     <= 1'b0;
         load_valid_q <= 1'b0;
         load_stall_q <= 1'b0;
         resp_live_q  <= 1'b0;
`ifdef LOAD_IO_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         io_timeout_q <= 1'b0;
`endif
      end else begin
         io_req_q <= 1'b0;
`ifdef LOAD_IO_TIMEOUT_EN
         io_timeout_q <= 1'b0;
`endif
         if (cap_en) begin
            cap_valid_q  <= is_load_d;
            cap_op_q     <= bus.opcode;
            cap_off_q    <= bus.ALUOut[1:0];
            cap_region_q <= region_d;
         end
         unique case (state_q)
            ST_IDLE, ST_RESP: begin
               if (cap_en) begin
                  if (is_load_d && region_d == RG_IO) begin
                     state_q      <= ST_IO_WAIT;
                     io_addr_q    <= bus.ALUOut;
                     io_req_q     <= 1'b1;
                     load_stall_q <= 1'b1;
                     load_valid_q <= 1'b0;
`ifdef LOAD_IO_TIMEOUT_EN
                     tmo_cnt_q    <= TW'(IO_TIMEOUT - 1);
`endif
                  end else if (is_load_d) begin
                     state_q      <= ST_RESP;
                     load_valid_q <= 1'b1;
                     resp_live_q  <= 1'b1;
                  end else begin
                     state_q      <= ST_IDLE;
                     load_valid_q <= 1'b0;
                  end
               end else if (state_q == ST_RESP && resp_live_q) begin
                  hold_q      <= live_data;
                  resp_live_q <= 1'b0;
               end
            end
            ST_IO_WAIT: begin
               if (bus.ioRdValid) begin
                  hold_q       <= align_load(cap_op_q, cap_off_q, bus.ioRdData);
                  state_q      <= ST_IO_DONE;
                  load_valid_q <= 1'b1;
                  load_stall_q <= 1'b0;
               end
`ifdef LOAD_IO_TIMEOUT_EN
               else if (tmo_cnt_q == '0) begin
                  hold_q       <= 32'h0;
                  state_q      <= ST_IO_DONE;
                  load_valid_q <= 1'b1;
                  load_stall_q <= 1'b0;
                  io_timeout_q <= 1'b1;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q - 1'b1;
               end
`endif
            end
            ST_IO_DONE: begin
               if (!bus.stall) begin
                  state_q      <= ST_IDLE;
                  load_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.ioRdReq   = io_req_q;
   assign bus.ioAddr    = io_addr_q;
   assign bus.loadData  = load_data;
   assign bus.loadValid = load_valid_q;
   assign bus.loadStall = load_stall_q;
`ifdef LOAD_IO_TIMEOUT_EN
   assign bus.ioTimeout = io_timeout_q;
`else
   assign bus.ioTimeout = 1'b0;
`endif
endmodule

// File: tb/tb_load_data_ctr.sv
// Directed bench for load_data_ctr: region decode, alignment, stalls, I/O handshake, reset abort
// and, when LOAD_IO_TIMEOUT_EN is defined, the I/O timeout.
module tb_load_data_ctr;
   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SW  = 6'h2B;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   load_data_ctr_if bus();

   load_data_ctr #(.IO_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      bus.opcode = OP_NOP; bus.ALUOut = 32'h0; bus.stall = 1'b0;
      bus.dataMemOut = 32'h1280_3456; bus.instrMemOut = 32'h7FFF_0000; bus.ISR_MemOut = 32'hAAAA_8001;
      bus.ioRdData = 32'h0; bus.ioRdValid = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({bus.ioRdReq, bus.loadValid, bus.loadStall, bus.ioTimeout} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.ioRdReq, bus.loadValid, bus.loadStall, bus.ioTimeout}); end
      checks++; if ({bus.ioAddr, bus.loadData} !== 64'h0) begin errors++; $display("FAIL reset_data: got ioAddr=%h loadData=%h want 0/0", bus.ioAddr, bus.loadData); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mem_loads();
      logic [5:0]  ops   [11] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LB, OP_LH, OP_LW, OP_SW, OP_LBU, OP_NOP};
      logic [31:0] addrs [11] = '{32'h1000_0001, 32'h1000_0001, 32'hC000_0002, 32'h2000_0000, 32'h3000_0000,
                                  32'h1000_0003, 32'h1000_0001, 32'h5000_0000, 32'h1000_0000, 32'hC000_0001, 32'h0};
      logic        exp_v [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] exp_d [11] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF, 32'h1280_3456,
                                  32'h0000_0056, 32'h0000_1280, 32'h0, 32'h0, 32'h0000_00AA, 32'h0};
      for (int i = 0; i < 11; i++) begin
         bus.opcode = ops[i];
         bus.ALUOut = addrs[i];
         @(negedge clk);
         checks++; if (bus.loadValid !== exp_v[i]) begin errors++; $display("FAIL mem_valid[%0d]: got %b want %b", i, bus.loadValid, exp_v[i]); end
         checks++; if (bus.loadData !== exp_d[i]) begin errors++; $display("FAIL mem_data[%0d]: got %h want %h", i, bus.loadData, exp_d[i]); end
      end
   endtask

   task automatic test_stall();
      bus.opcode = OP_LW; bus.ALUOut = 32'h1000_0000; bus.dataMemOut = 32'h1122_3344; bus.stall = 1'b1;
      @(negedge clk);
      checks++; if (bus.loadValid !== 1'b0) begin errors++; $display("FAIL stall_nocap1: got %b want 0", bus.loadValid); end
      @(negedge clk);
      checks++; if (bus.loadValid !== 1'b0) begin errors++; $display("FAIL stall_nocap2: got %b want 0", bus.loadValid); end
      bus.stall = 1'b0;
      @(negedge clk);
      checks++; if ({bus.loadValid, bus.loadData} !== {1'b1, 32'h1122_3344}) begin errors++; $display("FAIL stall_release: got %b/%h want 1/11223344", bus.loadValid, bus.loadData); end
      bus.stall = 1'b1; bus.opcode = OP_NOP;
      @(negedge clk);
      checks++; if ({bus.loadValid, bus.loadData} !== {1'b1, 32'h1122_3344}) begin errors++; $display("FAIL resp_hold1: got %b/%h want 1/11223344", bus.loadValid, bus.loadData); end
      bus.dataMemOut = 32'h5555_5555;
      @(negedge clk);
      checks++; if ({bus.loadValid, bus.loadData} !== {1'b1, 32'h1122_3344}) begin errors++; $display("FAIL resp_hold2: got %b/%h want 1/11223344", bus.loadValid, bus.loadData); end
      bus.stall = 1'b0;
      @(negedge clk);
      checks++; if (bus.loadValid !== 1'b0) begin errors++; $display("FAIL resp_exit: got %b want 0", bus.loadValid); end
      bus.dataMemOut = 32'h1280_3456;
   endtask

   task automatic test_io();
      int req_cnt = 0;
      int stall_cnt = 0;
      int tmo_cnt = 0;
      bus.opcode = OP_LW; bus.ALUOut = 32'h8000_0010;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         req_cnt   += int'(bus.ioRdReq);
         stall_cnt += int'(bus.loadStall);
         tmo_cnt   += int'(bus.ioTimeout);
         if (c == 1) begin
            bus.opcode = OP_NOP;
            checks++; if (bus.ioAddr !== 32'h8000_0010) begin errors++; $display("FAIL io_addr: got %h want 80000010", bus.ioAddr); end
         end
         if (c == 4) begin
            checks++; if (bus.loadValid !== 1'b0) begin errors++; $display("FAIL io_early_valid: got %b want 0", bus.loadValid); end
            bus.ioRdValid = 1'b1; bus.ioRdData = 32'hDEAD_BEEF;
         end
         if (c == 5) begin
            checks++; if ({bus.loadValid, bus.loadData} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL io_result: got %b/%h want 1/deadbeef", bus.loadValid, bus.loadData); end
            bus.ioRdValid = 1'b0; bus.stall = 1'b1;
         end
      end
      checks++; if (req_cnt !== 1) begin errors++; $display("FAIL io_req_pulses: got %0d want 1", req_cnt); end
      checks++; if (stall_cnt !== 4) begin errors++; $display("FAIL io_stall_cycles: got %0d want 4", stall_cnt); end
      checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL io_no_timeout: got %0d want 0", tmo_cnt); end
      @(negedge clk);
      checks++; if ({bus.loadValid, bus.loadData, bus.ioAddr} !== {1'b1, 32'hDEAD_BEEF, 32'h8000_0010}) begin errors++; $display("FAIL io_done_hold: got %b/%h/%h want 1/deadbeef/80000010", bus.loadValid, bus.loadData, bus.ioAddr); end
      bus.stall = 1'b0;
      @(negedge clk);
      checks++; if (bus.loadValid !== 1'b0) begin errors++; $display("FAIL io_done_exit: got %b want 0", bus.loadValid); end
      bus.ioRdValid = 1'b1; bus.ioRdData = 32'h1234_5678;
      @(negedge clk);
      checks++; if ({bus.loadValid, bus.loadStall} !== 2'b00) begin errors++; $display("FAIL io_stray_valid: got %b want 00", {bus.loadValid, bus.loadStall}); end
      bus.ioRdValid = 1'b0;
   endtask

   task automatic test_io_same_cycle();
      bus.opcode = OP_LB; bus.ALUOut = 32'h8000_0003;
      @(negedge clk);
      checks++; if ({bus.ioRdReq, bus.loadStall} !== 2'b11) begin errors++; $display("FAIL io_fast_req: got %b want 11", {bus.ioRdReq, bus.loadStall}); end
      bus.opcode = OP_NOP; bus.ioRdValid = 1'b1; bus.ioRdData = 32'h0000_00F0;
      @(negedge clk);
      checks++; if ({bus.loadValid, bus.loadData} !== {1'b1, 32'hFFFF_FFF0}) begin errors++; $display("FAIL io_fast_result: got %b/%h want 1/fffffff0", bus.loadValid, bus.loadData); end
      bus.ioRdValid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_io();
      int req_cnt = 0;
      bus.opcode = OP_LW; bus.ALUOut = 32'h8000_0020;
      @(negedge clk);
      bus.opcode = OP_NOP;
      @(negedge clk);
      checks++; if (bus.loadStall !== 1'b1) begin errors++; $display("FAIL rst_io_pre: got %b want 1", bus.loadStall); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({bus.ioRdReq, bus.loadValid, bus.loadStall, bus.ioTimeout, bus.ioAddr, bus.loadData} !== 68'h0) begin errors++; $display("FAIL rst_io_abort: got req=%b v=%b st=%b addr=%h data=%h want all 0", bus.ioRdReq, bus.loadValid, bus.loadStall, bus.ioAddr, bus.loadData); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         req_cnt += int'(bus.ioRdReq) + int'(bus.loadStall);
      end
      checks++; if (req_cnt !== 0) begin errors++; $display("FAIL rst_io_no_reissue: got %0d want 0", req_cnt); end
   endtask

`ifdef LOAD_IO_TIMEOUT_EN
   task automatic test_timeout();
      bus.opcode = OP_LW; bus.ALUOut = 32'h8000_0004;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) bus.opcode = OP_NOP;
         if (c == 4) begin
            checks++; if ({bus.ioTimeout, bus.loadStall} !== 2'b01) begin errors++; $display("FAIL tmo_wait4: got %b want 01", {bus.ioTimeout, bus.loadStall}); end
         end
      end
      checks++; if ({bus.ioTimeout, bus.loadValid, bus.loadData} !== {2'b11, 32'h0}) begin errors++; $display("FAIL tmo_fire: got %b/%b/%h want 1/1/0", bus.ioTimeout, bus.loadValid, bus.loadData); end
      @(negedge clk);
      checks++; if ({bus.ioTimeout, bus.loadValid} !== 2'b00) begin errors++; $display("FAIL tmo_pulse: got %b want 00", {bus.ioTimeout, bus.loadValid}); end
      bus.opcode = OP_LW; bus.ALUOut = 32'h8000_0008;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) bus.opcode = OP_NOP;
         if (c == 4) begin bus.ioRdValid = 1'b1; bus.ioRdData = 32'h1234_5678; end
      end
      checks++; if ({bus.ioTimeout, bus.loadValid, bus.loadData} !== {2'b01, 32'h1234_5678}) begin errors++; $display("FAIL tmo_race: got %b/%b/%h want 0/1/12345678", bus.ioTimeout, bus.loadValid, bus.loadData); end
      bus.ioRdValid = 1'b0;
      @(negedge clk);
   endtask
`else
   task automatic test_io_no_timeout();
      int tmo_cnt = 0;
      bus.opcode = OP_LW; bus.ALUOut = 32'h8000_0030;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) bus.opcode = OP_NOP;
         tmo_cnt += int'(bus.ioTimeout);
      end
      checks++; if ({bus.loadStall, bus.loadValid} !== 2'b10) begin errors++; $display("FAIL io_long_wait: got %b want 10", {bus.loadStall, bus.loadValid}); end
      bus.ioRdValid = 1'b1; bus.ioRdData = 32'hCAFE_F00D;
      @(negedge clk);
      bus.ioRdValid = 1'b0;
      checks++; if ({bus.loadValid, bus.loadData} !== {1'b1, 32'hCAFE_F00D}) begin errors++; $display("FAIL io_long_result: got %b/%h want 1/cafef00d", bus.loadValid, bus.loadData); end
      checks++; if (tmo_cnt !== 0) begin errors++; $display("FAIL io_long_timeout: got %0d want 0", tmo_cnt); end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_mem_loads();
      test_stall();
      test_io();
      test_io_same_cycle();
`ifdef LOAD_IO_TIMEOUT_EN
      test_timeout();
`else
      test_io_no_timeout();
`endif
      test_reset_mid_io();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
